// File: rtl/sha3_pkg.sv
// Shared SHA3-256 constants and padder state type, used by the padder,
// absorb and permutation stages.
package sha3_pkg;
    localparam int LANE_W     = 64;
    localparam int RATE_LANES = 17;
    localparam int RATE_BYTES = 136;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_END    = 8'h80;

    localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        EMIT,
        PAD
    } padder_state_t;
endpackage

// File: rtl/sha3_lane_pad.sv
// Masks the unused bytes of a lane and inserts the pad10*1 marker bytes:
// 0x06 right after the last message byte, 0x80 in the top byte of the block.
module sha3_lane_pad
    import sha3_pkg::*;
(
    input  logic [LANE_W-1:0] word,
    input  logic [3:0]        valid_bytes,
    input  logic              pad_start,
    input  logic              pad_end,
    output logic [LANE_W-1:0] lane
);

    always_comb begin
        lane = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < valid_bytes) begin
                lane[8*k +: 8] = word[8*k +: 8];
            end
            if (pad_start && (4'(k) == valid_bytes)) begin
                lane[8*k +: 8] = lane[8*k +: 8] | PAD_DOMAIN;
            end
        end
        // Both markers may land on byte 7 of lane 16, giving 0x86.
        if (pad_end) begin
            lane[63:56] = lane[63:56] | PAD_END;
        end
    end

endmodule

// File: rtl/sha3_padder.sv
// SHA3-256 padder: pulls message words from a FIFO and emits 17-lane rate
// blocks with pad10*1 applied, one lane per valid/ready handshake.
module sha3_padder
    import sha3_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         msg_len,
    input  logic [LANE_W-1:0]   fifo_data,
    input  logic                fifo_empty,
    output logic                fifo_rd,
    output logic [LANE_W-1:0]   lane_data,
    output logic                lane_valid,
    input  logic                lane_ready,
    output logic [4:0]          lane_idx,
    output logic                block_end,
    output logic                msg_end,
    output logic                busy,
    output logic                done
);

    padder_state_t state, state_next;

    logic [15:0]       len;
    logic [15:0]       byte_cnt;
    logic [4:0]        lane_cnt;
    logic              pad_seen;
    logic [3:0]        lane_bytes;
    logic              lane_pad;
    logic              lane_last;
    logic [LANE_W-1:0] lane_q;
    logic              done_q;

    logic [15:0]       remaining;
    logic [LANE_W-1:0] gen_word;
    logic [3:0]        gen_bytes;
    logic              gen_pad_start;
    logic              gen_pad_end;
    logic [LANE_W-1:0] gen_lane;

    // Describe the next lane: how many message bytes it carries and which markers it needs.
    always_comb begin
        remaining     = len - byte_cnt;
        gen_word      = '0;
        gen_bytes     = '0;
        gen_pad_start = 1'b0;
        if (state == CAPTURE) begin
            gen_word = fifo_data;
            if (remaining >= 16'd8) begin
                gen_bytes = 4'd8;
            end else begin
                gen_bytes     = {1'b0, remaining[2:0]};
                gen_pad_start = 1'b1;
            end
        end else begin
            gen_pad_start = !pad_seen;
        end
        gen_pad_end = (lane_cnt == LAST_LANE) && (pad_seen || gen_pad_start);
    end

    sha3_lane_pad u_lane_pad (
        .word        (gen_word),
        .valid_bytes (gen_bytes),
        .pad_start   (gen_pad_start),
        .pad_end     (gen_pad_end),
        .lane        (gen_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (msg_len == 16'd0) ? PAD : FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = EMIT;
            PAD:     state_next = EMIT;
            EMIT: begin
                if (lane_ready) begin
                    if (lane_last) begin
                        state_next = IDLE;
                    end else if ((byte_cnt + 16'(lane_bytes)) < len) begin
                        state_next = FETCH;
                    end else begin
                        state_next = PAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane register and message bookkeeping; counters advance only on a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            len        <= '0;
            byte_cnt   <= '0;
            lane_cnt   <= '0;
            pad_seen   <= 1'b0;
            lane_bytes <= '0;
            lane_pad   <= 1'b0;
            lane_last  <= 1'b0;
            lane_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len      <= msg_len;
                        byte_cnt <= '0;
                        lane_cnt <= '0;
                        pad_seen <= 1'b0;
                    end
                end
                CAPTURE, PAD: begin
                    lane_q     <= gen_lane;
                    lane_bytes <= gen_bytes;
                    lane_pad   <= gen_pad_start;
                    lane_last  <= gen_pad_end;
                end
                EMIT: begin
                    if (lane_ready) begin
                        byte_cnt <= byte_cnt + 16'(lane_bytes);
                        pad_seen <= pad_seen | lane_pad;
                        lane_cnt <= (lane_cnt == LAST_LANE) ? 5'd0 : lane_cnt + 5'd1;
                        done_q   <= lane_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset so an abandoned message cannot read or transfer.
    always_comb begin
        fifo_rd    = (state == FETCH) && !fifo_empty && !reset;
        lane_valid = (state == EMIT) && !reset;
        busy       = (state != IDLE);
        lane_data  = lane_q;
        lane_idx   = lane_cnt;
        block_end  = lane_valid && (lane_cnt == LAST_LANE);
        msg_end    = lane_valid && lane_last;
        done       = done_q;
    end

endmodule
